// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters under IDLE/RUN/HALT control, wrap or saturate on overflow.
// Define PERFCNT_SNAPSHOT_EN to add per-channel shadow registers loaded by snap and read via rd_data.
module perf_counter_bank #(
  parameter int NUM_CH     = 6,
  parameter int WIDTH      = 32,
  parameter int SATURATE   = 0,
  parameter int CH0_CYCLES = 1,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              snap,
  input  logic [NUM_CH-1:0] inc_en,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [WIDTH-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic              running
);

  // state | meaning
  // IDLE  | after reset, counters hold
  // RUN   | counters advance on their strobes
  // HALT  | stopped by stop, counters hold until restarted
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state;
  logic [WIDTH-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] hit;
  logic [WIDTH-1:0]  rd_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, HALT: if (start && !stop) state <= RUN;
        RUN:        if (stop && !start) state <= HALT;
        default:    state <= IDLE;
      endcase
    end
  end

  assign running = (state == RUN);

  always_comb begin
    hit = inc_en;
    if (CH0_CYCLES == 1) hit[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (hit[i]) begin
          if (cnt[i] == '1) begin
            ovf[i] <= 1'b1;
            if (SATURATE == 0) cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + WIDTH'(1);
          end
        end
      end
    end
  end

`ifdef PERFCNT_SNAPSHOT_EN
  logic [WIDTH-1:0] shadow [NUM_CH];

  // Shadows load the pre-edge live value, so snap+clear keeps the old counts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= cnt[i];
    end
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_sel == SEL_W'(i)) rd_next = shadow[i];
  end
`else
  logic unused_snap;
  assign unused_snap = snap;

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_sel == SEL_W'(i)) rd_next = cnt[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= rd_next;
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: wrap instance (a) and saturate instance (b) share stimulus.
module tb_perf_counter_bank;
  logic       clk = 1'b0;
  logic       reset, start, stop, clear, snap;
  logic [5:0] inc_en;
  logic [2:0] rd_sel;
  logic [7:0] rd_data_a, rd_data_b;
  logic [5:0] ovf_a, ovf_b;
  logic       running_a, running_b;
  int n_cmp = 0;
  int n_fail = 0;

  perf_counter_bank #(.NUM_CH(6), .WIDTH(8), .SATURATE(0), .CH0_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .snap(snap),
    .inc_en(inc_en), .rd_sel(rd_sel), .rd_data(rd_data_a), .ovf(ovf_a), .running(running_a));

  perf_counter_bank #(.NUM_CH(6), .WIDTH(8), .SATURATE(1), .CH0_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .snap(snap),
    .inc_en(inc_en), .rd_sel(rd_sel), .rd_data(rd_data_b), .ovf(ovf_b), .running(running_b));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Refresh shadows (no effect without snapshots) while stopped, then select the channel.
  task automatic read_ch(input int ch);
    snap = 1'b1; tick(); snap = 1'b0;
    rd_sel = 3'(ch); tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    n_cmp++; if (running_a !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running_a); end
    n_cmp++; if (ovf_a !== 6'd0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf_a); end
    n_cmp++; if (rd_data_a !== 8'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", rd_data_a); end
    start = 1'b1; tick(); start = 1'b0; inc_en = 6'h3f;
    repeat (10) tick();
    n_cmp++; if (running_a !== 1'b1) begin n_fail++; $display("FAIL run_before_reset: got %b want 1", running_a); end
    reset = 1'b0; start = 1'b1; tick(); reset = 1'b1; start = 1'b0; inc_en = '0;
    n_cmp++; if (running_a !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_running: got %b want 0", running_a); end
    n_cmp++; if (ovf_a !== 6'd0) begin n_fail++; $display("FAIL midrun_reset_ovf: got %b want 0", ovf_a); end
    for (int ch = 0; ch < 6; ch++) begin
      read_ch(ch);
      n_cmp++; if (rd_data_a !== 8'd0) begin n_fail++; $display("FAIL midrun_reset_ch%0d: got %0d want 0", ch, rd_data_a); end
    end
    n_cmp++; if (running_a !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored: got %b want 0", running_a); end
  endtask

  task automatic test_basic_count();
    inc_en = 6'b000010; start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (running_a !== 1'b1) begin n_fail++; $display("FAIL basic_running: got %b want 1", running_a); end
    repeat (6) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    n_cmp++; if (running_a !== 1'b0) begin n_fail++; $display("FAIL basic_stopped: got %b want 0", running_a); end
    repeat (3) tick();
    inc_en = '0;
    read_ch(1);
    n_cmp++; if (rd_data_a !== 8'd7) begin n_fail++; $display("FAIL basic_ch1: got %0d want 7", rd_data_a); end
    read_ch(0);
    n_cmp++; if (rd_data_a !== 8'd7) begin n_fail++; $display("FAIL basic_ch0_cycles: got %0d want 7", rd_data_a); end
    rd_sel = 3'd6; tick();
    n_cmp++; if (rd_data_a !== 8'd0) begin n_fail++; $display("FAIL rd_sel6_zero: got %0d want 0", rd_data_a); end
  endtask

  task automatic test_wrap();
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    inc_en = 6'b000100;
    repeat (257) tick();
    inc_en = '0; stop = 1'b1; tick(); stop = 1'b0;
    read_ch(2);
    n_cmp++; if (rd_data_a !== 8'd1) begin n_fail++; $display("FAIL wrap_ch2: got %0d want 1", rd_data_a); end
    n_cmp++; if (ovf_a[2] !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf2: got %b want 1", ovf_a[2]); end
    n_cmp++; if (ovf_a[3] !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf3_idle: got %b want 0", ovf_a[3]); end
    n_cmp++; if (rd_data_b !== 8'd255) begin n_fail++; $display("FAIL sat_ch2: got %0d want 255", rd_data_b); end
    clear = 1'b1; tick(); clear = 1'b0;
    n_cmp++; if (ovf_a !== 6'd0) begin n_fail++; $display("FAIL clear_ovf: got %b want 0", ovf_a); end
    read_ch(2);
    n_cmp++; if (rd_data_a !== 8'd0) begin n_fail++; $display("FAIL clear_ch2: got %0d want 0", rd_data_a); end
  endtask

  task automatic test_saturate();
    start = 1'b1; tick(); start = 1'b0;
    inc_en = 6'b001000;
    repeat (255) tick();
    inc_en = '0; stop = 1'b1; tick(); stop = 1'b0;
    read_ch(3);
    n_cmp++; if (rd_data_b !== 8'd255) begin n_fail++; $display("FAIL sat_at_max: got %0d want 255", rd_data_b); end
    n_cmp++; if (ovf_b[3] !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_early: got %b want 0", ovf_b[3]); end
    start = 1'b1; tick(); start = 1'b0;
    inc_en = 6'b001000;
    repeat (45) tick();
    inc_en = '0; stop = 1'b1; tick(); stop = 1'b0;
    read_ch(3);
    n_cmp++; if (rd_data_b !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", rd_data_b); end
    n_cmp++; if (ovf_b[3] !== 1'b1) begin n_fail++; $display("FAIL sat_ovf3: got %b want 1", ovf_b[3]); end
    n_cmp++; if (rd_data_a !== 8'd44) begin n_fail++; $display("FAIL wrap300_ch3: got %0d want 44", rd_data_a); end
    n_cmp++; if (ovf_a[3] !== 1'b1) begin n_fail++; $display("FAIL wrap300_ovf3: got %b want 1", ovf_a[3]); end
    rd_sel = 3'd7; tick();
    n_cmp++; if (rd_data_a !== 8'd0) begin n_fail++; $display("FAIL rd_sel7_zero: got %0d want 0", rd_data_a); end
  endtask

  task automatic test_snapshot();
    logic [7:0] exp_v;
`ifdef PERFCNT_SNAPSHOT_EN
    exp_v = 8'd5;
`else
    exp_v = 8'd3;
`endif
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    inc_en = 6'b000010; repeat (5) tick();
    inc_en = '0; stop = 1'b1; tick(); stop = 1'b0;
    snap = 1'b1; clear = 1'b1; tick(); snap = 1'b0; clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    inc_en = 6'b000010; repeat (3) tick();
    inc_en = '0; stop = 1'b1; tick(); stop = 1'b0;
    rd_sel = 3'd1; tick();
    n_cmp++; if (rd_data_a !== exp_v) begin n_fail++; $display("FAIL snap_clear_ch1: got %0d want %0d", rd_data_a, exp_v); end
  endtask

  task automatic test_collisions();
    reset = 1'b0; tick(); reset = 1'b1;
    start = 1'b1; stop = 1'b1; tick();
    n_cmp++; if (running_a !== 1'b0) begin n_fail++; $display("FAIL idle_start_stop: got %b want 0", running_a); end
    stop = 1'b0; tick();
    n_cmp++; if (running_a !== 1'b1) begin n_fail++; $display("FAIL idle_start: got %b want 1", running_a); end
    stop = 1'b1; inc_en = 6'b010000; tick();
    n_cmp++; if (running_a !== 1'b1) begin n_fail++; $display("FAIL run_start_stop: got %b want 1", running_a); end
    start = 1'b0; stop = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0; inc_en = '0;
    stop = 1'b1; tick(); stop = 1'b0;
    read_ch(4);
    n_cmp++; if (rd_data_a !== 8'd0) begin n_fail++; $display("FAIL clear_beats_inc: got %0d want 0", rd_data_a); end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    n_cmp++; if (running_a !== 1'b0) begin n_fail++; $display("FAIL halt_start_stop: got %b want 0", running_a); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; snap = 1'b0;
    inc_en = '0; rd_sel = '0;
    test_reset();
    test_basic_count();
    test_wrap();
    test_saturate();
    test_snapshot();
    test_collisions();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_CH, default 6, number of event counter channels (2..16).
REQ-002 Parameter WIDTH, default 32, bit width of every counter (8..64).
REQ-003 Parameter SATURATE, default 0, overflow mode: 0 = wrap to zero, 1 = hold at all-ones.
REQ-004 Parameter CH0_CYCLES, default 1, when 1 channel 0 counts every RUN cycle and ignores inc_en[0].
REQ-005 Port clk  input  1  single clock; all logic is on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-low reset.
REQ-007 Port start  input  1  pulse that requests entry into RUN.
REQ-008 Port stop  input  1  pulse that requests entry into HALT.
REQ-009 Port clear  input  1  synchronous clear of all counters and overflow flags.
REQ-010 Port snap  input  1  captures all live counters into shadow registers.
REQ-011 Port inc_en  input  NUM_CH  per-channel event strobe, +1 per asserted cycle.
REQ-012 Port rd_sel  input  max(1,$clog2(NUM_CH))  channel select for readout.
REQ-013 Port rd_data  output  WIDTH  registered readout of the selected channel.
REQ-014 Port ovf  output  NUM_CH  sticky per-channel overflow flags.
REQ-015 Port running  output  1  high while the FSM is in RUN.

Function
REQ-016 FSM states: IDLE, RUN, HALT; reset enters IDLE.
REQ-017 IDLE->RUN and HALT->RUN on start=1, stop=0; RUN->HALT on stop=1; start and stop asserted together leave the state unchanged.
REQ-018 Counters increment only in RUN; in IDLE and HALT they hold.
REQ-019 Increment takes effect at the edge that samples the strobe; a strobe on the cycle start is sampled is not counted, and a strobe on the cycle stop is sampled is counted.
REQ-020 Each asserted inc_en bit adds exactly 1; all channels update independently in the same cycle.
REQ-021 Wrap mode: all-ones +1 gives 0 and sets the channel ovf bit.
REQ-022 Saturate mode: the counter holds at all-ones, and ovf is set on the first attempted increment past all-ones.
REQ-023 ovf bits stay set until clear or reset.
REQ-024 clear zeroes every counter and ovf bit in any state, without changing state; clear wins over a simultaneous increment.
REQ-025 snap with clear in the same cycle captures the pre-clear values.
REQ-026 rd_data updates one cycle after rd_sel is sampled.
REQ-027 rd_sel >= NUM_CH returns 0.
REQ-028 running is asserted combinationally from state == RUN.

Reset
REQ-029 When reset=0 at an edge:
- counters, shadows, ovf and rd_data become 0;
- FSM enters IDLE and running goes to 0;
- all other inputs that cycle are ignored, including mid-RUN.

Configuration
REQ-030 Macro PERFCNT_SNAPSHOT_EN defined: per-channel shadow registers exist.
- snap loads every shadow from its live counter at that edge.
- rd_data reads the shadow.
REQ-031 Macro PERFCNT_SNAPSHOT_EN undefined: no shadows exist, snap is ignored, and rd_data reads the live counter.

Verification
REQ-032 Reset mid-RUN: reset=0 for 1 cycle after 10 RUN cycles -> running=0, rd_data=0 for all channels, ovf=0.
REQ-033 Basic count: start, then inc_en[1]=1 for 7 cycles, then stop (CH0_CYCLES=1) -> ch1=7, ch0=RUN cycle count, running=0 after stop.
REQ-034 Wrap: WIDTH=8, SATURATE=0, 257 strobes on ch2 -> ch2=1, ovf[2]=1; then clear -> ch2=0, ovf[2]=0.
REQ-035 Saturate: WIDTH=8, SATURATE=1, 300 strobes on ch3 -> ch3=255, ovf[3]=1.
REQ-036 Snapshot (macro defined): ch1=5, snap+clear in the same cycle, then 3 more strobes -> rd_data(sel=1)=5 and live ch1=3; macro undefined -> rd_data=3.
REQ-037 Collisions: start+stop in the same cycle while IDLE -> stays IDLE; clear+inc_en[4] in the same cycle -> ch4=0.
